// File: rtl/clock_display_pkg.sv
// Shared types, segment codes and digit helpers for the MM:SS multiplexed display driver.
package clock_display_pkg;

   typedef logic [6:0] seg_t;
   typedef logic [1:0] digit_idx_t;
   typedef logic [5:0] field_t;
   typedef logic [3:0] bcd_t;

   // Segment patterns are active-low, bit order {g,f,e,d,c,b,a}
   localparam seg_t SEG_BLANK = 7'b1111111;
   localparam seg_t SEG_DASH  = 7'b0111111;

   localparam seg_t SEG_DIGIT [0:9] = '{
      7'b1000000,
      7'b1111001,
      7'b0100100,
      7'b0110000,
      7'b0011001,
      7'b0010010,
      7'b0000010,
      7'b1111000,
      7'b0000000,
      7'b0010000
   };

   localparam field_t     MAX_VALID = 6'd59;
   localparam digit_idx_t IDX_LAST  = 2'd3;
   localparam digit_idx_t IDX_COLON = 2'd2;
   localparam logic [3:0] AN_OFF    = 4'b1111;

   function automatic bcd_t ones_of(input field_t v);
      return bcd_t'(v % 6'd10);
   endfunction

   function automatic bcd_t tens_of(input field_t v);
      return bcd_t'(v / 6'd10);
   endfunction

   // Active-low one-cold anode pattern for the selected digit
   function automatic logic [3:0] anode_sel(input digit_idx_t idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/clock_display_driver_if.sv
// Bundle between the clock counter / board pins and the display driver.
interface clock_display_driver_if;
   import clock_display_pkg::*;

   field_t     seconds;
   field_t     minutes;
   logic [3:0] an;
   seg_t       seg;
   logic       dp;
   logic       frame_done;

   // Counter and board side
   modport master (
      output seconds,
      output minutes,
      input  an,
      input  seg,
      input  dp,
      input  frame_done
   );

   // Display driver side
   modport slave (
      input  seconds,
      input  minutes,
      output an,
      output seg,
      output dp,
      output frame_done
   );

endinterface

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low 7-segment decoder with a dash for invalid fields.
module seg7_decoder
   import clock_display_pkg::*;
(
   input  bcd_t bcd,
   input  logic invalid,
   output seg_t seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (invalid) begin
         seg = SEG_DASH;
      end else if (bcd <= 4'd9) begin
         seg = SEG_DIGIT[bcd];
      end
   end

endmodule

// File: rtl/clock_display_driver.sv
// Four-digit multiplexed MM:SS display driver with per-frame snapshot,
// anti-ghosting blanking at each slot start and a 0.5 Hz colon.
module clock_display_driver
   import clock_display_pkg::*;
#(
   parameter int REFRESH_DIV  = 1000,
   parameter int BLANK_CYCLES = 2
)
(
   input  logic                  clk,
   input  logic                  reset,
   clock_display_driver_if.slave disp
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   // Slot timer runs down; cycles remaining in the slot = cnt
   localparam logic [CW-1:0] CNT_LOAD   = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(REFRESH_DIV - 1 - BLANK_CYCLES);

   logic [CW-1:0] cnt;
   digit_idx_t    idx;
   field_t        snap_sec;
   field_t        snap_min;

   logic [3:0]    an_q;
   seg_t          seg_q;
   logic          dp_q;
   logic          frame_done_q;

   logic          tick;
   logic          blank;
   logic          frame_end;
   bcd_t          digit_bcd;
   logic          digit_inv;
   seg_t          dec_seg;
   logic [3:0]    an_nxt;
   seg_t          seg_nxt;
   logic          dp_nxt;

   assign tick      = (cnt == '0);
   assign blank     = (cnt > BLANK_LAST);
   assign frame_end = tick && (idx == IDX_LAST);

   always_comb begin
      digit_bcd = '0;
      digit_inv = 1'b0;
      unique case (idx)
         2'd0: begin
            digit_bcd = ones_of(snap_sec);
            digit_inv = (snap_sec > MAX_VALID);
         end
         2'd1: begin
            digit_bcd = tens_of(snap_sec);
            digit_inv = (snap_sec > MAX_VALID);
         end
         2'd2: begin
            digit_bcd = ones_of(snap_min);
            digit_inv = (snap_min > MAX_VALID);
         end
         2'd3: begin
            digit_bcd = tens_of(snap_min);
            digit_inv = (snap_min > MAX_VALID);
         end
         default: begin
            digit_bcd = '0;
            digit_inv = 1'b0;
         end
      endcase
   end

   seg7_decoder u_dec (
      .bcd     (digit_bcd),
      .invalid (digit_inv),
      .seg     (dec_seg)
   );

   // Colon follows snap_sec[0] even when the seconds field shows dashes
   always_comb begin
      an_nxt  = AN_OFF;
      seg_nxt = SEG_BLANK;
      dp_nxt  = 1'b1;
      if (!blank) begin
         an_nxt  = anode_sel(idx);
         seg_nxt = dec_seg;
         dp_nxt  = !((idx == IDX_COLON) && !snap_sec[0]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt          <= CNT_LOAD;
         idx          <= '0;
         snap_sec     <= '0;
         snap_min     <= '0;
         an_q         <= AN_OFF;
         seg_q        <= SEG_BLANK;
         dp_q         <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         if (tick) begin
            cnt <= CNT_LOAD;
            idx <= idx + 2'd1;
         end else begin
            cnt <= cnt - 1'b1;
         end
         if (frame_end) begin
            snap_sec <= disp.seconds;
            snap_min <= disp.minutes;
         end
         frame_done_q <= frame_end;
         an_q         <= an_nxt;
         seg_q        <= seg_nxt;
         dp_q         <= dp_nxt;
      end
   end

   assign disp.an         = an_q;
   assign disp.seg        = seg_q;
   assign disp.dp         = dp_q;
   assign disp.frame_done = frame_done_q;

endmodule

// File: tb/tb_clock_display_driver.sv
// Bench for clock_display_driver: time-based reference model checked every cycle,
// plus directed literal expectations at chosen cycles.
module tb_clock_display_driver;

   localparam int RD    = 8;
   localparam int BL    = 2;
   localparam int FRAME = 4 * RD;

   localparam logic [6:0] SEG_TBL [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };
   localparam logic [6:0] DASH = 7'b0111111;
   localparam logic [3:0] AN_TBL [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   logic clk   = 1'b0;
   logic reset = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int fd_seen  = 0;
   int fd_base  = 0;

   clock_display_driver_if disp();

   clock_display_driver #(
      .REFRESH_DIV  (RD),
      .BLANK_CYCLES (BL)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .disp  (disp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cyc %0d: got %b expected %b", name, cyc, act, exp);
      end
   endtask

   // Reference model: state after k edges since release is a pure function of k
   // and the inputs seen at each frame boundary; outputs lag that state by one edge.
   int         n_edges;
   int         m_sec;
   int         m_min;
   int         pre;
   int         p;
   int         slot;
   int         val;
   bit         inv;
   bit         blank;
   bit         mvalid = 1'b0;
   logic [3:0] e_an;
   logic [6:0] e_seg;
   logic       e_dp;
   logic       e_fd;

   always @(posedge clk) begin
      if (reset) begin
         n_edges = 0;
         m_sec   = 0;
         m_min   = 0;
         e_an    = 4'b1111;
         e_seg   = 7'b1111111;
         e_dp    = 1'b1;
         e_fd    = 1'b0;
      end else begin
         pre = n_edges;
         n_edges++;
         p     = pre % RD;
         slot  = (pre / RD) % 4;
         blank = (p < BL);
         case (slot)
            0:       begin val = m_sec % 10; inv = (m_sec > 59); end
            1:       begin val = m_sec / 10; inv = (m_sec > 59); end
            2:       begin val = m_min % 10; inv = (m_min > 59); end
            default: begin val = m_min / 10; inv = (m_min > 59); end
         endcase
         if (blank) begin
            e_an  = 4'b1111;
            e_seg = 7'b1111111;
         end else begin
            e_an  = AN_TBL[slot];
            e_seg = inv ? DASH : SEG_TBL[val];
         end
         e_dp = !(!blank && slot == 2 && (m_sec % 2) == 0);
         e_fd = ((n_edges % FRAME) == 0);
         if (e_fd) begin
            m_sec = int'(disp.seconds);
            m_min = int'(disp.minutes);
         end
      end
      mvalid = 1'b1;
   end

   always @(negedge clk) begin
      if (mvalid) begin
         chk("model_an", 8'(disp.an), 8'(e_an));
         chk("model_seg", 8'(disp.seg), 8'(e_seg));
         chk("model_dp", 8'(disp.dp), 8'(e_dp));
         chk("model_frame_done", 8'(disp.frame_done), 8'(e_fd));
         if (disp.frame_done === 1'b1) fd_seen++;
      end
   end

   task automatic goto(input int t);
      while (cyc < t) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic lit(input string name, input logic [3:0] an, input logic [6:0] seg);
      chk({name, "_an"}, 8'(disp.an), 8'(an));
      chk({name, "_seg"}, 8'(disp.seg), 8'(seg));
   endtask

   initial begin
      disp.seconds = 6'd0;
      disp.minutes = 6'd0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      lit("reset_hold", 4'b1111, 7'b1111111);
      chk("reset_hold_dp", 8'(disp.dp), 8'd1);
      chk("reset_hold_fd", 8'(disp.frame_done), 8'd0);

      reset = 1'b0;
      cyc = 0;
      fd_base = fd_seen;
      disp.seconds = 6'd37;
      disp.minutes = 6'd12;

      goto(3);  lit("first_frame_d0", 4'b1110, 7'b1000000);
      goto(33); lit("slot0_blank", 4'b1111, 7'b1111111);
      goto(36); lit("f2_slot0", 4'b1110, 7'b1111000);
      goto(44); lit("f2_slot1", 4'b1101, 7'b0110000);
      goto(52); lit("f2_slot2", 4'b1011, 7'b0100100);
      chk("f2_slot2_dp", 8'(disp.dp), 8'd1);
      goto(60); lit("f2_slot3", 4'b0111, 7'b1111001);

      goto(70); disp.seconds = 6'd10;
      goto(97); chk("frame_done_count", 8'(fd_seen - fd_base), 8'd3);
      goto(100); lit("sec10_slot0", 4'b1110, 7'b1000000);
      disp.seconds = 6'd11;
      goto(116); chk("sec10_dp", 8'(disp.dp), 8'd0);
      goto(132); lit("sec11_slot0", 4'b1110, 7'b1111001);
      goto(148); chk("sec11_dp", 8'(disp.dp), 8'd1);

      goto(150); disp.seconds = 6'd63; disp.minutes = 6'd5;
      goto(164); lit("inv_slot0", 4'b1110, 7'b0111111);
      goto(172); lit("inv_slot1", 4'b1101, 7'b0111111);
      goto(180); lit("inv_slot2", 4'b1011, 7'b0010010);
      chk("inv_dp", 8'(disp.dp), 8'd1);
      goto(188); lit("inv_slot3", 4'b0111, 7'b1000000);

      goto(190); disp.seconds = 6'd59; disp.minutes = 6'd59;
      goto(196); lit("max_slot0", 4'b1110, 7'b0010000);
      goto(204); lit("max_slot1", 4'b1101, 7'b0010010);
      goto(205); disp.seconds = 6'd0; disp.minutes = 6'd0;
      goto(212); lit("wrap_held", 4'b1011, 7'b0010000);
      goto(228); lit("wrap_shown", 4'b1110, 7'b1000000);

      goto(255); disp.seconds = 6'd42; disp.minutes = 6'd3;
      goto(256); disp.seconds = 6'd17;
      goto(260); lit("edge_slot0", 4'b1110, 7'b0100100);
      goto(268); lit("edge_slot1", 4'b1101, 7'b0011001);
      goto(276); lit("edge_slot2", 4'b1011, 7'b0110000);
      chk("edge_dp", 8'(disp.dp), 8'd0);

      goto(277);
      reset = 1'b1;
      @(negedge clk);
      lit("mid_reset", 4'b1111, 7'b1111111);
      chk("mid_reset_dp", 8'(disp.dp), 8'd1);
      chk("mid_reset_fd", 8'(disp.frame_done), 8'd0);
      reset = 1'b0;
      cyc = 0;
      goto(3);  lit("post_reset_d0", 4'b1110, 7'b1000000);
      goto(36); lit("post_reset_f2_s0", 4'b1110, 7'b1111000);
      goto(44); lit("post_reset_f2_s1", 4'b1101, 7'b1111001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
